// File: rtl/doorlock_pkg.sv
// Shared state encoding, key codes and key classification for the keypad door-lock controller.
package doorlock_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTRY   = 3'd1,
        CHECK   = 3'd2,
        OPEN    = 3'd3,
        ERROR   = 3'd4,
        LOCKOUT = 3'd5,
        SET_NEW = 3'd6
    } state_t;

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_CLEAR = 4'hB;
    localparam logic [3:0] KEY_SET   = 4'hC;

    function automatic logic is_digit(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

endpackage

// File: rtl/doorlock_fsm_hold_timer.sv
// Loadable down-counter shared by the timed states; it parks at zero instead of wrapping.
module hold_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         run,
    output logic         done
);

    logic [W-1:0] count_r;

    // Load wins over counting; counting stops at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {W{1'b0}};
        end else if (load) begin
            count_r <= value;
        end else if (run && (count_r != {W{1'b0}})) begin
            count_r <= count_r - W'(1'b1);
        end else begin
            count_r <= count_r;
        end
    end

    assign done = run && (count_r == {W{1'b0}});

endmodule

// File: rtl/doorlock_fsm.sv
// Keypad door-lock controller: BCD code entry, compare, timed unlock / error / lockout.
// Define DOORLOCK_PW_CHANGE_EN to allow changing the password with SET while open.
module doorlock_fsm
    import doorlock_pkg::*;
#(
    parameter int                  PW_LEN         = 4,
    parameter logic [PW_LEN*4-1:0] DEFAULT_PW     = 16'h1234,
    parameter int                  OPEN_CYCLES    = 150_000_000,
    parameter int                  ERR_CYCLES     = 50_000_000,
    parameter int                  LOCKOUT_CYCLES = 500_000_000,
    parameter int                  MAX_FAIL       = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         key_valid,
    input  logic [3:0]                   key_code,
    output logic                         unlocked,
    output logic                         err,
    output logic                         locked_out,
    output logic [$clog2(PW_LEN+1)-1:0]  digit_cnt,
    output logic                         evt_toggle
);

    localparam int BUF_W   = PW_LEN * 4;
    localparam int CNT_W   = $clog2(PW_LEN + 1);
    localparam int MAX_A   = (OPEN_CYCLES > ERR_CYCLES) ? OPEN_CYCLES : ERR_CYCLES;
    localparam int MAX_CYC = (MAX_A > LOCKOUT_CYCLES) ? MAX_A : LOCKOUT_CYCLES;
    localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int FAIL_W  = (MAX_FAIL > 1) ? $clog2(MAX_FAIL) : 1;

    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(PW_LEN);
    localparam logic [TMR_W-1:0]  OPEN_LOAD = TMR_W'(OPEN_CYCLES - 1);
    localparam logic [TMR_W-1:0]  ERR_LOAD  = TMR_W'(ERR_CYCLES - 1);
    localparam logic [TMR_W-1:0]  LOCK_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);
    localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_FAIL - 1);

    state_t              state_r, state_next_s;
    logic [BUF_W-1:0]    buffer_r, buffer_next_s, shifted_s, pw_s;
    logic [CNT_W-1:0]    digit_cnt_r, cnt_next_s;
    logic [FAIL_W-1:0]   fail_cnt_r, fail_next_s;
    logic                unlocked_r, err_r, locked_out_r, evt_toggle_r;
    logic                accept_s, key_ok_s, match_s;
    logic                tmr_load_s, tmr_en_s, tmr_done_s;
    logic [TMR_W-1:0]    tmr_val_s;

    hold_timer #(.W(TMR_W)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (tmr_load_s),
        .value (tmr_val_s),
        .run   (tmr_en_s),
        .done  (tmr_done_s)
    );

    assign tmr_en_s  = (state_r == OPEN) || (state_r == ERROR) || (state_r == LOCKOUT);
    // A strobe landing on the expiry cycle loses to the timeout.
    assign key_ok_s  = key_valid && !tmr_done_s;
    assign shifted_s = (buffer_r << 3'd4) | BUF_W'(key_code);
    assign match_s   = (digit_cnt_r == FULL_CNT) && (buffer_r == pw_s);

`ifdef DOORLOCK_PW_CHANGE_EN
    logic [BUF_W-1:0] pw_r, pw_next_s;

    // Stored password, rewritten only from SET_NEW.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pw_r <= DEFAULT_PW;
        end else begin
            pw_r <= pw_next_s;
        end
    end

    assign pw_s = pw_r;
`else
    assign pw_s = DEFAULT_PW;
`endif

    // Next-state, entry-buffer, fail-count and timer-load decode.
    always_comb begin
        state_next_s  = state_r;
        buffer_next_s = buffer_r;
        cnt_next_s    = digit_cnt_r;
        fail_next_s   = fail_cnt_r;
        tmr_load_s    = 1'b0;
        tmr_val_s     = {TMR_W{1'b0}};
        accept_s      = 1'b0;
`ifdef DOORLOCK_PW_CHANGE_EN
        pw_next_s     = pw_r;
`endif
        case (state_r)
            IDLE: begin
                if (key_ok_s && is_digit(key_code)) begin
                    buffer_next_s = shifted_s;
                    cnt_next_s    = CNT_W'(1'b1);
                    state_next_s  = ENTRY;
                    accept_s      = 1'b1;
                end else begin
                    state_next_s  = IDLE;
                end
            end
            ENTRY: begin
                if (key_ok_s && is_digit(key_code) && (digit_cnt_r < FULL_CNT)) begin
                    buffer_next_s = shifted_s;
                    cnt_next_s    = digit_cnt_r + CNT_W'(1'b1);
                    accept_s      = 1'b1;
                end else if (key_ok_s && (key_code == KEY_CLEAR)) begin
                    state_next_s  = IDLE;
                    accept_s      = 1'b1;
                end else if (key_ok_s && (key_code == KEY_ENTER)) begin
                    state_next_s  = CHECK;
                    accept_s      = 1'b1;
                end else begin
                    state_next_s  = ENTRY;
                end
            end
            CHECK: begin
                tmr_load_s = 1'b1;
                if (match_s) begin
                    state_next_s = OPEN;
                    fail_next_s  = {FAIL_W{1'b0}};
                    tmr_val_s    = OPEN_LOAD;
                end else if (fail_cnt_r == FAIL_LAST) begin
                    state_next_s = LOCKOUT;
                    tmr_val_s    = LOCK_LOAD;
                end else begin
                    state_next_s = ERROR;
                    fail_next_s  = fail_cnt_r + FAIL_W'(1'b1);
                    tmr_val_s    = ERR_LOAD;
                end
            end
            OPEN: begin
                if (tmr_done_s) begin
                    state_next_s  = IDLE;
                end else if (key_ok_s && (key_code == KEY_CLEAR)) begin
                    state_next_s  = IDLE;
                    accept_s      = 1'b1;
`ifdef DOORLOCK_PW_CHANGE_EN
                end else if (key_ok_s && (key_code == KEY_SET)) begin
                    state_next_s  = SET_NEW;
                    buffer_next_s = {BUF_W{1'b0}};
                    cnt_next_s    = {CNT_W{1'b0}};
                    accept_s      = 1'b1;
`endif
                end else begin
                    state_next_s  = OPEN;
                end
            end
            ERROR: begin
                if (tmr_done_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = ERROR;
                end
            end
            LOCKOUT: begin
                if (tmr_done_s) begin
                    state_next_s = IDLE;
                    fail_next_s  = {FAIL_W{1'b0}};
                end else begin
                    state_next_s = LOCKOUT;
                end
            end
`ifdef DOORLOCK_PW_CHANGE_EN
            SET_NEW: begin
                if (key_ok_s && is_digit(key_code) && (digit_cnt_r < FULL_CNT)) begin
                    buffer_next_s = shifted_s;
                    cnt_next_s    = digit_cnt_r + CNT_W'(1'b1);
                    accept_s      = 1'b1;
                end else if (key_ok_s && (key_code == KEY_ENTER) && (digit_cnt_r == FULL_CNT)) begin
                    pw_next_s     = buffer_r;
                    state_next_s  = IDLE;
                    accept_s      = 1'b1;
                end else if (key_ok_s && (key_code == KEY_ENTER)) begin
                    state_next_s  = ERROR;
                    tmr_load_s    = 1'b1;
                    tmr_val_s     = ERR_LOAD;
                    accept_s      = 1'b1;
                end else if (key_ok_s && (key_code == KEY_CLEAR)) begin
                    state_next_s  = IDLE;
                    accept_s      = 1'b1;
                end else begin
                    state_next_s  = SET_NEW;
                end
            end
`endif
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered status; landing in IDLE always wipes the entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            buffer_r     <= {BUF_W{1'b0}};
            digit_cnt_r  <= {CNT_W{1'b0}};
            fail_cnt_r   <= {FAIL_W{1'b0}};
            unlocked_r   <= 1'b0;
            err_r        <= 1'b0;
            locked_out_r <= 1'b0;
            evt_toggle_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            buffer_r     <= (state_next_s == IDLE) ? {BUF_W{1'b0}} : buffer_next_s;
            digit_cnt_r  <= (state_next_s == IDLE) ? {CNT_W{1'b0}} : cnt_next_s;
            fail_cnt_r   <= fail_next_s;
            unlocked_r   <= (state_next_s == OPEN) || (state_next_s == SET_NEW);
            err_r        <= (state_next_s == ERROR);
            locked_out_r <= (state_next_s == LOCKOUT);
            evt_toggle_r <= evt_toggle_r ^ accept_s;
        end
    end

    assign unlocked   = unlocked_r;
    assign err        = err_r;
    assign locked_out = locked_out_r;
    assign digit_cnt  = digit_cnt_r;
    assign evt_toggle = evt_toggle_r;

endmodule

// File: tb/tb_doorlock_fsm.sv
// Self-checking bench for doorlock_fsm with shortened timing (open 20, error 8, lockout 30 cycles).
// Follows DOORLOCK_PW_CHANGE_EN when that macro is defined for the build.
module tb_doorlock_fsm;
    import doorlock_pkg::*;

    localparam int OPEN_C = 20;
    localparam int ERR_C  = 8;
    localparam int LOCK_C = 30;
    localparam int MAX_F  = 3;

    localparam int M_IDLE = 0, M_ENTRY = 1, M_CHECK = 2, M_OPEN = 3, M_ERROR = 4, M_LOCK = 5, M_SET = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_valid;
    logic [3:0] key_code;
    logic       unlocked, err, locked_out, evt_toggle;
    logic [2:0] digit_cnt;

    int   n_pass  = 0;
    int   n_total = 0;
    int   flips   = 0;
    logic last_tog = 1'b0;

    // Behavioural reference: phase, cycles left in phase, typed digits, password digits.
    int   m_mode;
    int   m_left;
    int   m_fail;
    int   m_digits[$];
    int   m_pw[4];
    logic m_tog;

    always #5 clk = ~clk;

    doorlock_fsm #(
        .PW_LEN(4), .DEFAULT_PW(16'h1234), .OPEN_CYCLES(OPEN_C),
        .ERR_CYCLES(ERR_C), .LOCKOUT_CYCLES(LOCK_C), .MAX_FAIL(MAX_F)
    ) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .unlocked(unlocked), .err(err), .locked_out(locked_out),
        .digit_cnt(digit_cnt), .evt_toggle(evt_toggle)
    );

    task automatic model_reset();
        m_mode = M_IDLE; m_left = 0; m_fail = 0; m_tog = 1'b0;
        m_digits.delete();
        m_pw = '{1, 2, 3, 4};
        last_tog = 1'b0;
    endtask

    function automatic bit m_match();
        if (m_digits.size() != 4) return 1'b0;
        for (int i = 0; i < 4; i++) if (m_digits[i] != m_pw[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic go_idle();
        m_mode = M_IDLE;
        m_digits.delete();
    endtask

    task automatic model_step(input bit v, input int code);
        bit acc;
        acc = 1'b0;
        case (m_mode)
            M_IDLE: if (v && code <= 9) begin m_digits.push_back(code); m_mode = M_ENTRY; acc = 1'b1; end
            M_ENTRY: if (v) begin
                if (code <= 9) begin
                    if (m_digits.size() < 4) begin m_digits.push_back(code); acc = 1'b1; end
                end else if (code == 10) begin m_mode = M_CHECK; acc = 1'b1; end
                else if (code == 11) begin go_idle(); acc = 1'b1; end
            end
            M_CHECK: begin
                if (m_match()) begin m_mode = M_OPEN; m_left = OPEN_C; m_fail = 0; end
                else if (m_fail + 1 == MAX_F) begin m_mode = M_LOCK; m_left = LOCK_C; end
                else begin m_fail++; m_mode = M_ERROR; m_left = ERR_C; end
            end
            M_OPEN: begin
                if (m_left == 1) go_idle();
                else begin
                    m_left--;
                    if (v && code == 11) begin go_idle(); acc = 1'b1; end
`ifdef DOORLOCK_PW_CHANGE_EN
                    else if (v && code == 12) begin m_mode = M_SET; m_digits.delete(); acc = 1'b1; end
`endif
                end
            end
            M_ERROR: if (m_left == 1) go_idle(); else m_left--;
            M_LOCK: if (m_left == 1) begin go_idle(); m_fail = 0; end else m_left--;
            M_SET: if (v) begin
                if (code <= 9) begin
                    if (m_digits.size() < 4) begin m_digits.push_back(code); acc = 1'b1; end
                end else if (code == 10) begin
                    acc = 1'b1;
                    if (m_digits.size() == 4) begin
                        for (int i = 0; i < 4; i++) m_pw[i] = m_digits[i];
                        go_idle();
                    end else begin
                        m_mode = M_ERROR; m_left = ERR_C;
                    end
                end else if (code == 11) begin go_idle(); acc = 1'b1; end
            end
            default: ;
        endcase
        if (acc) m_tog = ~m_tog;
    endtask

    task automatic cycle(input bit v, input logic [3:0] c);
        key_valid = v;
        key_code  = c;
        @(posedge clk);
        model_step(v, int'(c));
        #1;
        key_valid = 1'b0;
        if (evt_toggle !== last_tog) flips++;
        last_tog = evt_toggle;
    endtask

    task automatic press(input logic [3:0] c);
        cycle(1'b1, c);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 4'h0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        #12;
        n_total++; if (unlocked !== 1'b0) $display("FAIL reset_unlocked: got %0b want 0", unlocked); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL reset_err: got %0b want 0", err); else n_pass++;
        n_total++; if (locked_out !== 1'b0) $display("FAIL reset_locked_out: got %0b want 0", locked_out); else n_pass++;
        n_total++; if (digit_cnt !== 3'd0) $display("FAIL reset_digit_cnt: got %0d want 0", digit_cnt); else n_pass++;
        n_total++; if (evt_toggle !== 1'b0) $display("FAIL reset_evt_toggle: got %0b want 0", evt_toggle); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_open();
        int hi;
        flips = 0;
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        n_total++; if (digit_cnt !== 3'd4) $display("FAIL open_digit_cnt: got %0d want 4", digit_cnt); else n_pass++;
        press(KEY_ENTER);
        n_total++; if (unlocked !== 1'b0) $display("FAIL open_early: unlocked=%0b one cycle after ENTER, want 0", unlocked); else n_pass++;
        idle(1);
        n_total++; if (unlocked !== 1'b1) $display("FAIL open_rise: unlocked=%0b two cycles after ENTER, want 1", unlocked); else n_pass++;
        hi = 1;
        for (int i = 0; i < 40; i++) begin
            idle(1);
            if (unlocked) hi++; else break;
        end
        n_total++; if (hi != OPEN_C) $display("FAIL open_width: high %0d cycles, want %0d", hi, OPEN_C); else n_pass++;
        n_total++; if (flips != 5) $display("FAIL open_toggles: %0d flips, want 5", flips); else n_pass++;
    endtask

    task automatic test_lockout();
        int hi;
        for (int a = 0; a < 2; a++) begin
            press(4'd1); press(4'd2); press(4'd3); press(4'd5); press(KEY_ENTER);
            hi = 0;
            for (int i = 0; i < 40; i++) begin
                idle(1);
                if (err) hi++; else if (hi > 0) break;
            end
            n_total++; if (hi != ERR_C) $display("FAIL err_width: attempt %0d err high %0d cycles, want %0d", a, hi, ERR_C); else n_pass++;
        end
        press(4'd1); press(4'd2); press(4'd3); press(4'd5); press(KEY_ENTER);
        flips = 0;
        hi = 0;
        for (int i = 0; i < 60; i++) begin
            press(4'($urandom_range(0, 12)));
            if (locked_out) hi++; else if (hi > 0) break;
        end
        n_total++; if (hi != LOCK_C) $display("FAIL lockout_width: high %0d cycles, want %0d", hi, LOCK_C); else n_pass++;
        n_total++; if (flips != 0) $display("FAIL lockout_keys: %0d flips during lockout, want 0", flips); else n_pass++;
        press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(KEY_ENTER); idle(1);
        n_total++; if (unlocked !== 1'b1) $display("FAIL lockout_recover: unlocked=%0b want 1", unlocked); else n_pass++;
        idle(22);
    endtask

    task automatic test_short_and_overflow();
        int f;
        press(4'd1); press(4'd2); press(KEY_ENTER); idle(1);
        n_total++; if (err !== 1'b1) $display("FAIL short_code: err=%0b want 1", err); else n_pass++;
        idle(10);
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        f = flips;
        press(4'd9);
        n_total++; if (flips != f) $display("FAIL overflow_toggle: %0d flips, want %0d", flips, f); else n_pass++;
        n_total++; if (digit_cnt !== 3'd4) $display("FAIL overflow_cnt: got %0d want 4", digit_cnt); else n_pass++;
        press(KEY_ENTER); idle(1);
        n_total++; if (unlocked !== 1'b1) $display("FAIL overflow_open: unlocked=%0b want 1", unlocked); else n_pass++;
        idle(22);
    endtask

    task automatic test_clear();
        press(4'd1); press(4'd2); press(KEY_CLEAR);
        n_total++; if (digit_cnt !== 3'd0) $display("FAIL clear_cnt: got %0d want 0", digit_cnt); else n_pass++;
        press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(KEY_ENTER); idle(1);
        n_total++; if (unlocked !== 1'b1) $display("FAIL clear_open: unlocked=%0b want 1", unlocked); else n_pass++;
        idle(3);
        press(KEY_CLEAR);
        n_total++; if (unlocked !== 1'b0) $display("FAIL clear_relock: unlocked=%0b want 0", unlocked); else n_pass++;
        idle(2);
    endtask

    task automatic test_rst_mid();
        press(4'd1); press(4'd2); press(4'd3);
        n_total++; if (digit_cnt !== 3'd3) $display("FAIL rst_pre_cnt: got %0d want 3", digit_cnt); else n_pass++;
        rst = 1'b1; #2;
        n_total++; if (digit_cnt !== 3'd0) $display("FAIL rst_entry_cnt: got %0d want 0", digit_cnt); else n_pass++;
        n_total++; if (evt_toggle !== 1'b0) $display("FAIL rst_entry_toggle: got %0b want 0", evt_toggle); else n_pass++;
        model_reset();
        @(posedge clk); #1; rst = 1'b0;
        press(4'd1);
        n_total++; if (digit_cnt !== 3'd1) $display("FAIL rst_release_idle: cnt=%0d want 1", digit_cnt); else n_pass++;
        press(4'd2); press(4'd3); press(4'd4); press(KEY_ENTER); idle(4);
        n_total++; if (unlocked !== 1'b1) $display("FAIL rst_open: unlocked=%0b want 1", unlocked); else n_pass++;
        rst = 1'b1; #2;
        n_total++; if (unlocked !== 1'b0) $display("FAIL rst_open_async: unlocked=%0b want 0", unlocked); else n_pass++;
        n_total++; if ({err, locked_out, digit_cnt} !== 5'd0) $display("FAIL rst_open_outs: got %05b want 0", {err, locked_out, digit_cnt}); else n_pass++;
        model_reset();
        @(posedge clk); #1; rst = 1'b0;
        idle(1);
    endtask

    task automatic test_set();
        int f;
        press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(KEY_ENTER); idle(3);
        f = flips;
        press(KEY_SET);
`ifdef DOORLOCK_PW_CHANGE_EN
        n_total++; if (flips != f + 1) $display("FAIL set_accept: %0d flips, want %0d", flips, f + 1); else n_pass++;
        idle(25);
        n_total++; if (unlocked !== 1'b1) $display("FAIL set_frozen: unlocked=%0b want 1", unlocked); else n_pass++;
        press(4'd9); press(4'd8); press(4'd7); press(4'd6); press(KEY_ENTER);
        n_total++; if (unlocked !== 1'b0) $display("FAIL set_store: unlocked=%0b want 0", unlocked); else n_pass++;
        press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(KEY_ENTER); idle(1);
        n_total++; if (err !== 1'b1) $display("FAIL set_old_pw: err=%0b want 1", err); else n_pass++;
        idle(10);
        press(4'd9); press(4'd8); press(4'd7); press(4'd6); press(KEY_ENTER); idle(1);
        n_total++; if (unlocked !== 1'b1) $display("FAIL set_new_pw: unlocked=%0b want 1", unlocked); else n_pass++;
        idle(22);
`else
        n_total++; if (flips != f) $display("FAIL set_ignored_open: %0d flips, want %0d", flips, f); else n_pass++;
        n_total++; if (unlocked !== 1'b1) $display("FAIL set_still_open: unlocked=%0b want 1", unlocked); else n_pass++;
        idle(25);
        n_total++; if (unlocked !== 1'b0) $display("FAIL set_no_freeze: unlocked=%0b want 0", unlocked); else n_pass++;
        f = flips;
        press(KEY_SET);
        n_total++; if (flips != f) $display("FAIL set_ignored_idle: %0d flips, want %0d", flips, f); else n_pass++;
        press(4'd1); press(KEY_SET);
        n_total++; if (flips != f + 1) $display("FAIL set_ignored_entry: %0d flips, want %0d", flips, f + 1); else n_pass++;
        press(KEY_CLEAR);
`endif
    endtask

    task automatic test_random();
        int fails0;
        fails0 = n_total - n_pass;
        for (int i = 0; i < 4000; i++) begin
            bit         v;
            logic [3:0] c;
            int         r;
            v = ($urandom_range(0, 99) < 45);
            r = $urandom_range(0, 99);
            if (r < 60 && m_digits.size() < 4) c = 4'(m_pw[m_digits.size()]);
            else if (r < 80) c = KEY_ENTER;
            else if (r < 85) c = KEY_CLEAR;
            else if (r < 90) c = KEY_SET;
            else c = 4'($urandom_range(0, 15));
            cycle(v, c);
            n_total++; if (unlocked !== (m_mode == M_OPEN || m_mode == M_SET)) $display("FAIL rnd_unlocked @%0d: got %0b", i, unlocked); else n_pass++;
            n_total++; if (err !== (m_mode == M_ERROR)) $display("FAIL rnd_err @%0d: got %0b", i, err); else n_pass++;
            n_total++; if (locked_out !== (m_mode == M_LOCK)) $display("FAIL rnd_locked_out @%0d: got %0b", i, locked_out); else n_pass++;
            n_total++; if (int'(digit_cnt) != m_digits.size()) $display("FAIL rnd_digit_cnt @%0d: got %0d want %0d", i, digit_cnt, m_digits.size()); else n_pass++;
            n_total++; if (evt_toggle !== m_tog) $display("FAIL rnd_evt_toggle @%0d: got %0b want %0b", i, evt_toggle, m_tog); else n_pass++;
            if ((n_total - n_pass) > fails0 + 20) break;
        end
    endtask

    initial begin
        key_valid = 1'b0;
        key_code  = 4'h0;
        rst       = 1'b1;
        test_reset();
        test_open();
        test_lockout();
        test_short_and_overflow();
        test_clear();
        test_rst_mid();
        test_set();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
